// File: rtl/du_program_loader_if.sv
// du_program_loader_if: UART byte input, start pulse, instruction-memory write port and status of the program loader
interface du_program_loader_if #(
  parameter int NB_DATA  = 32,
  parameter int NB_BYTE  = 8,
  parameter int NB_ADDR  = 8,
  parameter int NB_STATE = 3
);
  logic [NB_BYTE-1:0]  i_rx_data;
  logic                i_rx_done;
  logic                i_start;
  logic                o_imem_write;
  logic [NB_ADDR-1:0]  o_imem_addr;
  logic [NB_DATA-1:0]  o_imem_data;
  logic                o_busy;
  logic                o_load_done;
  logic                o_load_error;
  logic [NB_ADDR:0]    o_word_count;
  logic [NB_STATE-1:0] o_state;
  modport master (
    output i_rx_data, i_rx_done, i_start,
    input  o_imem_write, o_imem_addr, o_imem_data, o_busy, o_load_done, o_load_error, o_word_count, o_state
  );
  modport slave (
    input  i_rx_data, i_rx_done, i_start,
    output o_imem_write, o_imem_addr, o_imem_data, o_busy, o_load_done, o_load_error, o_word_count, o_state
  );
endinterface

// File: rtl/du_program_loader.sv
// du_program_loader: assembles UART bytes into instruction words and writes them to instruction memory from address 0
module du_program_loader #(
  parameter int                    NB_DATA        = 32,
  parameter int                    NB_BYTE        = 8,
  parameter int                    NB_ADDR        = 8,
  parameter logic [NB_DATA-1:0]    HALT_WORD      = 32'hFFFFFFFF,
  parameter int                    NB_TIMEOUT     = 24,
  parameter logic [NB_TIMEOUT-1:0] TIMEOUT_CYCLES = 24'd5000000,
  parameter int                    NB_STATE       = 3
) (
  input logic               i_clock,
  input logic               i_reset,
  du_program_loader_if.slave bus
);
  localparam int NB_CNT = NB_ADDR + 1;
  localparam int NB_SHIFT = NB_DATA - NB_BYTE;
  localparam logic [NB_STATE-1:0] S_IDLE    = NB_STATE'(0);
  localparam logic [NB_STATE-1:0] S_RECEIVE = NB_STATE'(1);
  localparam logic [NB_STATE-1:0] S_WRITE   = NB_STATE'(2);
  localparam logic [NB_STATE-1:0] S_DONE    = NB_STATE'(3);
  localparam logic [NB_STATE-1:0] S_ERROR   = NB_STATE'(4);

  logic [NB_STATE-1:0]   r_state;
  logic [NB_ADDR-1:0]    r_addr;
  logic [1:0]            r_byte_cnt;
  logic [NB_SHIFT-1:0]   r_shift;
  logic [NB_TIMEOUT-1:0] r_timeout;
  logic [NB_CNT-1:0]     r_word_count;
  logic [NB_ADDR-1:0]    r_imem_addr;
  logic [NB_DATA-1:0]    r_imem_data;
  logic [NB_TIMEOUT-1:0] w_timeout_next;
  logic [NB_DATA-1:0]    w_word;

  assign w_timeout_next = r_timeout + NB_TIMEOUT'(1);
  assign w_word         = {r_shift, bus.i_rx_data};

  // Load sequencer: byte assembly, inter-byte timeout, one-cycle word write and termination
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_timeout    <= '0;
      r_word_count <= '0;
      r_imem_addr  <= '0;
      r_imem_data  <= '0;
    end else begin
      case (r_state)
        S_RECEIVE:
          if (bus.i_rx_done) begin
            r_shift    <= w_word[NB_SHIFT-1:0];
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_timeout  <= '0;
            if (r_byte_cnt == 2'd3) begin
              r_state      <= S_WRITE;
              r_imem_addr  <= r_addr;
              r_imem_data  <= w_word;
              r_word_count <= r_word_count + NB_CNT'(1);
            end
          end else if (r_byte_cnt != 2'd0) begin
            r_timeout <= w_timeout_next;
            if (w_timeout_next == TIMEOUT_CYCLES) r_state <= S_ERROR;
          end
        S_WRITE:
          if (r_imem_data == HALT_WORD) r_state <= S_DONE;
          else if (r_addr == {NB_ADDR{1'b1}}) r_state <= S_ERROR;
          else begin
            r_state <= S_RECEIVE;
            r_addr  <= r_addr + NB_ADDR'(1);
            if (bus.i_rx_done) begin
              r_shift    <= w_word[NB_SHIFT-1:0];
              r_byte_cnt <= 2'd1;
              r_timeout  <= '0;
            end
          end
        S_IDLE, S_DONE, S_ERROR:
          if (bus.i_start) begin
            r_state      <= S_RECEIVE;
            r_addr       <= '0;
            r_byte_cnt   <= '0;
            r_timeout    <= '0;
            r_word_count <= '0;
          end
        default: r_state <= S_IDLE;
      endcase
    end

  assign bus.o_imem_write = r_state == S_WRITE;
  assign bus.o_imem_addr  = r_imem_addr;
  assign bus.o_imem_data  = r_imem_data;
  assign bus.o_busy       = (r_state == S_RECEIVE) || (r_state == S_WRITE);
  assign bus.o_load_done  = r_state == S_DONE;
  assign bus.o_load_error = r_state == S_ERROR;
  assign bus.o_word_count = r_word_count;
  assign bus.o_state      = r_state;
endmodule

// File: tb/tb_du_program_loader.sv
// tb_du_program_loader: table, directed and random checks of the program loader against a program-level model
module tb_du_program_loader;
  localparam int NA = 2;
  localparam int DEPTH = 1 << NA;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  typedef struct packed {
    logic [0:5][31:0] w;
    int n;
    int gap;
    int nw;
    bit dn;
    bit er;
  } vec_t;

  logic clk = 0;
  logic rst = 0;
  int passed = 0;
  int total = 0;
  logic [NA+31:0] wq[$];

  du_program_loader_if #(.NB_ADDR(NA)) bus();
  du_program_loader #(.NB_ADDR(NA), .TIMEOUT_CYCLES(24'd100)) dut (.i_clock(clk), .i_reset(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.o_imem_write) wq.push_back({bus.o_imem_addr, bus.o_imem_data});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1;
    tick();
    bus.i_rx_done = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      if (gap > 0) tick(gap);
      send_byte(w[31-8*k -: 8]);
    end
  endtask

  task automatic start();
    bus.i_start = 1;
    tick();
    bus.i_start = 0;
  endtask

  function automatic void model(input logic [0:5][31:0] w, input int n, output int nw, output bit dn, output bit er);
    nw = 0; dn = 0; er = 0;
    for (int i = 0; i < n; i++)
      if (!dn && !er) begin
        nw++;
        if (w[i] == HALT) dn = 1;
        else if (nw == DEPTH) er = 1;
      end
  endfunction

  task automatic run_prog(input string nm, input logic [0:5][31:0] w, input int n, input int gap,
                          input int nw, input bit dn, input bit er);
    wq.delete();
    start();
    for (int i = 0; i < n; i++) send_word(w[i], gap < 0 ? int'($urandom_range(3)) : gap);
    tick(3);
    chk({nm, " writes"}, wq.size(), nw);
    for (int i = 0; i < wq.size() && i < nw; i++) begin
      chk({nm, " addr"}, wq[i][NA+31:32], i);
      chk({nm, " data"}, wq[i][31:0], w[i]);
    end
    chk({nm, " done"}, bus.o_load_done, dn);
    chk({nm, " error"}, bus.o_load_error, er);
    chk({nm, " count"}, bus.o_word_count, nw);
    chk({nm, " busy"}, bus.o_busy, 0);
  endtask

  vec_t tbl[6] = '{
    '{w: '{32'h20010005, HALT, 0, 0, 0, 0}, n: 2, gap: 1, nw: 2, dn: 1, er: 0},
    '{w: '{32'h1, 32'h2, 32'h3, 32'h4, HALT, 0}, n: 5, gap: 0, nw: 4, dn: 0, er: 1},
    '{w: '{HALT, 0, 0, 0, 0, 0}, n: 1, gap: 2, nw: 1, dn: 1, er: 0},
    '{w: '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, HALT, 0, 0}, n: 4, gap: 0, nw: 4, dn: 1, er: 0},
    '{w: '{32'h12345678, HALT, 32'h87654321, 0, 0, 0}, n: 3, gap: 1, nw: 2, dn: 1, er: 0},
    '{w: '{32'hDEADBEEF, 32'hFFFFFFFE, HALT, 0, 0, 0}, n: 3, gap: 0, nw: 3, dn: 1, er: 0}
  };

  initial begin
    logic [0:5][31:0] rw;
    int nw;
    bit dn, er;
    bus.i_rx_data = 0;
    bus.i_rx_done = 0;
    bus.i_start = 0;
    #2 rst = 1;
    #1;
    chk("reset state", bus.o_state, 0);
    chk("reset busy", bus.o_busy, 0);
    chk("reset write", bus.o_imem_write, 0);
    chk("reset addr", bus.o_imem_addr, 0);
    chk("reset data", bus.o_imem_data, 0);
    chk("reset done", bus.o_load_done, 0);
    chk("reset error", bus.o_load_error, 0);
    chk("reset count", bus.o_word_count, 0);
    tick(2);
    rst = 0;
    tick();

    wq.delete();
    start();
    chk("p1 state receive", bus.o_state, 1);
    chk("p1 busy", bus.o_busy, 1);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00);
    chk("p1 no early write", bus.o_imem_write, 0);
    send_byte(8'h05);
    chk("p1 write latency", bus.o_imem_write, 1);
    chk("p1 addr0", bus.o_imem_addr, 0);
    chk("p1 data0", bus.o_imem_data, 32'h20010005);
    chk("p1 count during write", bus.o_word_count, 1);
    tick();
    chk("p1 write one cycle", bus.o_imem_write, 0);
    chk("p1 addr held", bus.o_imem_addr, 0);
    chk("p1 data held", bus.o_imem_data, 32'h20010005);
    send_word(HALT, 1);
    chk("p1 write halt", bus.o_imem_write, 1);
    chk("p1 addr1", bus.o_imem_addr, 1);
    chk("p1 data1", bus.o_imem_data, HALT);
    tick();
    chk("p1 done", bus.o_load_done, 1);
    chk("p1 error", bus.o_load_error, 0);
    chk("p1 count", bus.o_word_count, 2);
    chk("p1 busy idle", bus.o_busy, 0);
    chk("p1 state done", bus.o_state, 3);
    send_byte(8'h55);
    chk("p1 rx ignored in done", bus.o_state, 3);
    chk("p1 total writes", wq.size(), 2);

    start();
    chk("restart done cleared", bus.o_load_done, 0);
    chk("restart count cleared", bus.o_word_count, 0);
    chk("restart state", bus.o_state, 1);
    send_word(HALT, 0);
    chk("restart addr0", bus.o_imem_addr, 0);
    tick();
    chk("restart done", bus.o_load_done, 1);
    chk("restart count", bus.o_word_count, 1);

    for (int i = 0; i < 6; i++) run_prog($sformatf("tbl%0d", i), tbl[i].w, tbl[i].n, tbl[i].gap, tbl[i].nw, tbl[i].dn, tbl[i].er);

    wq.delete();
    start();
    send_word(32'h11223344, 0);
    send_word(32'hAABBCCDD, 0);
    send_word(HALT, 0);
    tick(2);
    chk("overlap writes", wq.size(), 3);
    if (wq.size() > 1) chk("overlap word1", wq[1], {2'd1, 32'hAABBCCDD});
    chk("overlap done", bus.o_load_done, 1);

    wq.delete();
    start();
    send_byte(8'h12); send_byte(8'h34);
    tick(99);
    chk("timeout not yet", bus.o_state, 1);
    tick();
    chk("timeout state", bus.o_state, 4);
    chk("timeout error", bus.o_load_error, 1);
    chk("timeout no write", wq.size(), 0);

    start();
    tick(500);
    chk("idle no timeout", bus.o_state, 1);
    send_word(HALT, 0);
    tick();
    chk("idle then halt done", bus.o_load_done, 1);
    chk("idle then halt error", bus.o_load_error, 0);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 6; i++) rw[i] = ($urandom_range(3) == 0) ? HALT : $urandom;
      model(rw, 6, nw, dn, er);
      run_prog($sformatf("rand%0d", r), rw, 6, -1, nw, dn, er);
    end

    start();
    send_word(32'hCAFEF00D, 0);
    send_byte(8'h01); send_byte(8'h02);
    rst = 1;
    #1;
    chk("midreset state", bus.o_state, 0);
    chk("midreset busy", bus.o_busy, 0);
    chk("midreset write", bus.o_imem_write, 0);
    chk("midreset addr", bus.o_imem_addr, 0);
    chk("midreset data", bus.o_imem_data, 0);
    chk("midreset count", bus.o_word_count, 0);
    chk("midreset flags", {bus.o_load_done, bus.o_load_error}, 0);
    tick();
    rst = 0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/du_program_loader.md
Name: du_program_loader

Overview:
- Sits directly downstream of the byte-wide UART receiver in the debug unit, beside the command receiver.
- When started, assembles incoming UART bytes into 32-bit instruction words and writes them sequentially into instruction memory from word address 0.
- Stops on a halt-instruction word, on memory full, or on an inter-byte timeout.
- Reports done/error status to the debug unit and the host-side protocol.

Parameters:
- NB_DATA, 32, instruction word width.
- NB_BYTE, 8, UART byte width.
- NB_ADDR, 8, instruction memory word-address width (2^NB_ADDR words).
- HALT_WORD, 32'hFFFFFFFF, end-of-program instruction encoding.
- NB_TIMEOUT, 24, timeout counter width.
- TIMEOUT_CYCLES, 24'd5000000, maximum idle clocks allowed between bytes of one word.
- NB_STATE, 3, state output width.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_data  in  NB_BYTE  received UART byte; valid when i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse per received byte.
- i_start  in  1  one-cycle pulse that begins a program load.
- o_imem_write  out  1  one-cycle instruction-memory write enable.
- o_imem_addr  out  NB_ADDR  word address for the write.
- o_imem_data  out  NB_DATA  word to write.
- o_busy  out  1  high in RECEIVE and WRITE.
- o_load_done  out  1  level; program loaded, halt word written.
- o_load_error  out  1  level; overflow or timeout.
- o_word_count  out  NB_ADDR+1  words written in the current/last load, halt word included.
- o_state  out  NB_STATE  current FSM state.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; internal address, byte counter, shift register and timeout counter all 0.
- Reset asserted mid-load aborts immediately; partial words are discarded and nothing is written.
- State encoding: IDLE=0, RECEIVE=1, WRITE=2, DONE=3, ERROR=4.
- IDLE:
  - i_start -> RECEIVE next cycle; address, byte count and word count cleared.
  - i_rx_done is ignored.
- RECEIVE:
  - On each i_rx_done: shift register <= {shift[23:0], i_rx_data}, so the first byte lands in [31:24]; byte_cnt increments; timeout counter clears.
  - On the 4th byte -> WRITE next cycle; byte_cnt returns to 0.
  - Timeout counter increments each clock without i_rx_done, but only while byte_cnt != 0. When it reaches TIMEOUT_CYCLES -> ERROR; no write occurs.
  - Latency: o_imem_write asserts exactly 1 cycle after the 4th i_rx_done.
- WRITE (exactly 1 cycle):
  - o_imem_write=1, o_imem_addr=current address, o_imem_data=assembled word; o_word_count increments in the same cycle.
  - Word == HALT_WORD -> DONE.
  - Else if address == 2^NB_ADDR-1 -> ERROR (memory full, no halt seen); the word is still written.
  - Else address += 1 -> RECEIVE.
  - i_rx_done in WRITE: if the next state is RECEIVE, the byte is taken as byte 0 of the next word (byte_cnt=1); otherwise it is dropped.
- o_imem_addr and o_imem_data hold their last values outside WRITE; only o_imem_write qualifies them.
- DONE and ERROR:
  - o_load_done (DONE) or o_load_error (ERROR) is held high; i_rx_done is ignored.
  - i_start restarts the load: both flags clear, o_word_count clears, -> RECEIVE.
- i_start while in RECEIVE or WRITE is ignored.
- o_busy = (state==RECEIVE) || (state==WRITE).
- Address never wraps: overflow always ends in ERROR, never a write to address 0.

Test Plan:
- Reset, then i_start; send bytes 20,01,00,05 and FF,FF,FF,FF.
  -> write addr0=32'h20010005 one cycle after the 4th byte, then addr1=32'hFFFFFFFF; DONE; o_load_done=1; o_word_count=2; o_busy=0.
- Override NB_ADDR=2; send 4 non-halt words.
  -> writes at addr 0..3; ERROR after the 4th write; o_load_error=1; o_word_count=4; no 5th write.
- Override TIMEOUT_CYCLES=100; send 2 bytes, then idle 100 clocks.
  -> ERROR; o_load_error=1; no write.
- Same override; idle 500 clocks after i_start before the first byte, then a complete halt word.
  -> no timeout; DONE.
- Pulse i_rx_done in the same cycle as a non-final WRITE.
  -> that byte becomes [31:24] of the next word.
- Assert i_reset after 6 bytes of a load.
  -> state IDLE; all outputs 0.
- From DONE, pulse i_start and send FFFFFFFF.
  -> flags clear; write at addr 0; DONE; o_word_count=1.
